// File: rtl/instr_encoder_pkg.sv
// ----------------------------------------------------------------------------
// instr_encoder_pkg
//   Shared RV32 opcode header. It holds the request operation enum,
//   the opcode/funct3/funct7 constants and the canonical NOP word.
//   The CPU decoder uses the same opcode constants, so the encoder and
//   the decoder always agree on the instruction layout.
// ----------------------------------------------------------------------------
package instr_encoder_pkg;

    // Front-end operation codes (4-bit). Values 9..15 are illegal.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_MUL  = 4'd4,
        OP_ADDI = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_BEQ  = 4'd8
    } req_op_e;

    // Major opcodes
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    // funct7
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Encoder result: instruction word plus an error flag for that word.
    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } enc_result_t;

endpackage

// File: rtl/instr_fifo.sv
// ----------------------------------------------------------------------------
// instr_fifo
//   Synchronous FIFO holding encoded instruction words.
//   Ports:
//     clk_i     : clock, rising edge
//     rst_n     : asynchronous active-low reset (control state only)
//     flush_i   : empties the FIFO; wins over push and pop
//     push_i    : write wdata_i when not full
//     wdata_i   : word to store
//     pop_i     : drop head word when not empty
//     rdata_o   : head word, zero while empty
//     full_o    : FIFO holds DEPTH words
//     empty_o   : FIFO holds no words
//     count_o   : occupancy, 0..DEPTH
//   A push into a full FIFO is dropped even if a pop happens in the
//   same cycle, so full_o alone decides acceptance.
// ----------------------------------------------------------------------------
module instr_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count == FULL_CNT);
    assign empty_o = (count == '0);
    assign count_o = count;

    assign do_push = push_i && !full_o  && !flush_i;
    assign do_pop  = pop_i  && !empty_o && !flush_i;

    // Storage is data-only; it is never read while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Zero while empty so the memory data bus reads 0 out of reset.
    assign rdata_o = empty_o ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Packs field-level requests (op, rd, rs1, rs2, imm) into RV32
//   instruction words. It buffers them in instr_fifo and streams them to
//   instruction memory at consecutive word addresses starting at
//   BASE_ADDR.
//   Ports:
//     clk_i, rst_i       : clock; asynchronous active-low reset
//     req_valid_i/ready_o: request handshake (ready = FIFO not full)
//     req_op_i           : ADD..BEQ = 0..8, 9..15 illegal (encoded as NOP)
//     req_rd/rs1/rs2_i   : register indices
//     req_imm_i          : signed immediate (BEQ offset in halfwords)
//     flush_i            : drop buffered words, rewind address
//     mem_we_o/addr/data : instruction-memory write port
//     mem_ack_i          : memory accepted the current write
//     count_o            : FIFO occupancy
//     err_o, err_clr_i   : sticky encode error and its clear
//   Optional feature macro IMM_RANGE_CHECK_EN: immediates for ADDI, LW,
//   SW and BEQ outside [-2048, 2047] become NOP and raise err_o.
//   Without the macro, the immediate is silently truncated to imm[11:0].
// ----------------------------------------------------------------------------
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [3:0]             req_op_i,
    input  logic [4:0]             req_rd_i,
    input  logic [4:0]             req_rs1_i,
    input  logic [4:0]             req_rs2_i,
    input  logic [31:0]            req_imm_i,
    input  logic                   flush_i,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [31:0]            mem_data_o,
    input  logic                   mem_ack_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   err_o,
    input  logic                   err_clr_i
);

    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    // True when the upper immediate bits are a pure sign extension of
    // bit 11, i.e. the value fits a signed 12-bit field.
    function automatic logic imm_fits_12(input logic [31:11] imm_hi);
        return (&imm_hi) || !(|imm_hi);
    endfunction

    // Field packer. For BEQ the request immediate is already in halfword
    // units, so imm[11:0] maps directly onto B-type bits 12:1.
    function automatic enc_result_t encode(
        input logic [3:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm,
        input logic        imm_ok
    );
        enc_result_t r;
        r.word = NOP_INSTR;
        r.err  = 1'b0;
        case (op)
            OP_ADD: r.word = {F7_BASE,   rs2, rs1, F3_ADD_SUB, rd, OPC_R};
            OP_SUB: r.word = {F7_SUB,    rs2, rs1, F3_ADD_SUB, rd, OPC_R};
            OP_AND: r.word = {F7_BASE,   rs2, rs1, F3_AND,     rd, OPC_R};
            OP_OR:  r.word = {F7_BASE,   rs2, rs1, F3_OR,      rd, OPC_R};
            OP_MUL: r.word = {F7_MULDIV, rs2, rs1, F3_ADD_SUB, rd, OPC_R};
            OP_ADDI: begin
                if (imm_ok) r.word = {imm, rs1, F3_ADD_SUB, rd, OPC_IMM};
                else        r.err  = 1'b1;
            end
            OP_LW: begin
                if (imm_ok) r.word = {imm, rs1, F3_WORD, rd, OPC_LOAD};
                else        r.err  = 1'b1;
            end
            OP_SW: begin
                if (imm_ok) r.word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
                else        r.err  = 1'b1;
            end
            OP_BEQ: begin
                if (imm_ok) r.word = {imm[11], imm[9:4], rs2, rs1, F3_BEQ,
                                      imm[3:0], imm[10], OPC_BRANCH};
                else        r.err  = 1'b1;
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    logic        imm_ok;
    logic        unused_imm_hi;
    enc_result_t enc_p0;
    logic        vld_p0;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [ADDR_W-1:0] addr_q;
    logic        err_q;

    // Bits 31:12 only matter to the optional range check.
    assign unused_imm_hi = ^req_imm_i[31:12];

`ifdef IMM_RANGE_CHECK_EN
    assign imm_ok = imm_fits_12(req_imm_i[31:11]);
`else
    assign imm_ok = 1'b1;
    logic unused_fits_fn;
    assign unused_fits_fn = imm_fits_12(21'd0);
`endif

    // ---- Stage p0: combinational encode, captured into the FIFO on push ----
    assign enc_p0 = encode(req_op_i, req_rd_i, req_rs1_i, req_rs2_i,
                           req_imm_i[11:0], imm_ok);
    assign vld_p0 = req_valid_i && !fifo_full && !flush_i;

    assign req_ready_o = !fifo_full;

    instr_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n   (rst_i),
        .flush_i (flush_i),
        .push_i  (vld_p0),
        .wdata_i (enc_p0.word),
        .pop_i   (pop),
        .rdata_o (mem_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    // ---- Stage p1: FIFO head presented to instruction memory ----
    assign mem_we_o = !fifo_empty;
    assign pop      = mem_we_o && mem_ack_i && !flush_i;

    // Write address advances only on an accepted write and wraps naturally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q <= BASE_ADDR;
        end else if (flush_i) begin
            addr_q <= BASE_ADDR;
        end else if (pop) begin
            addr_q <= addr_q + WORD_STEP;
        end
    end

    assign mem_addr_o = addr_q;

    // Sticky error: a new error wins over a simultaneous clear; flush
    // leaves it alone.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (err_q && !err_clr_i) || (vld_p0 && enc_p0.err);
        end
    end

    assign err_o = err_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs field-level instruction requests (operation, register indices, immediate) into 32-bit RV32 instruction words and streams them into instruction memory at consecutive word addresses. It is the inverse of the CPU's immediate decode path: every immediate it packs is recovered bit-exact by the decoder. It sits between the testbench/loader front end and the instruction-memory write port, buffering requests in a small FIFO so the front end is decoupled from memory back-pressure.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 32, instruction-memory byte-address width.
- BASE_ADDR, 0, address of the first word written after reset or flush.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  encoder can accept; equals !full.
- req_op_i  input  4  operation: ADD=0, SUB=1, AND=2, OR=3, MUL=4, ADDI=5, LW=6, SW=7, BEQ=8; 9-15 illegal.
- req_rd_i / req_rs1_i / req_rs2_i  input  5 each  register indices.
- req_imm_i  input  32  signed immediate; BEQ offset is in halfword units.
- flush_i  input  1  drop buffered words and rewind the address.
- mem_we_o  output  1  write request to instruction memory.
- mem_addr_o  output  ADDR_W  byte address of the write.
- mem_data_o  output  32  encoded instruction.
- mem_ack_i  input  1  memory accepted the write this cycle.
- count_o  output  $clog2(DEPTH)+1  FIFO occupancy.
- err_o  output  1  sticky encode error.
- err_clr_i  input  1  clears err_o.

## Operation
- Encoding happens combinationally on the request fields and is captured on push (req_valid_i && req_ready_o).
- R-type (opcode 0110011): funct7 0000000 for ADD/AND/OR, 0100000 for SUB, 0000001 for MUL; funct3 000 for ADD/SUB/MUL, 111 for AND, 110 for OR. req_imm_i is ignored.
- ADDI: opcode 0010011, funct3 000, instr[31:20]=imm[11:0].
- LW: opcode 0000011, funct3 010, instr[31:20]=imm[11:0].
- SW: opcode 0100011, funct3 010, instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]; rd is ignored.
- BEQ: opcode 1100011, funct3 000, instr[31]=imm[11], instr[7]=imm[10], instr[30:25]=imm[9:4], instr[11:8]=imm[3:0]; rd is ignored.
- An illegal op writes NOP 0x00000013 and sets err_o.
- FIFO head drives mem_data_o. mem_we_o = !empty. Pop on mem_we_o && mem_ack_i; the address register then advances by 4 and wraps modulo 2^ADDR_W.
- Full FIFO: req_ready_o is low and there is no push, even when a pop occurs in the same cycle.
- Priority: flush_i over push/pop. Flush empties the FIFO and sets the address to BASE_ADDR.
- err_o: a new error in the same cycle as err_clr_i leaves err_o set. flush_i does not clear err_o.

## Timing
- Reset values: req_ready_o=1, mem_we_o=0, mem_addr_o=BASE_ADDR, mem_data_o=0, count_o=0, err_o=0.
- Reset mid-stream discards buffered words immediately; no partial write is issued.
- Latency: a request pushed at edge N has mem_we_o high from cycle N+1 at the earliest.
- Throughput: one push and one pop per cycle at steady state.
- err_o rises the cycle after the offending push.
- mem_data_o and mem_addr_o hold stable while mem_we_o is high and mem_ack_i is low.

## Configuration
- IMM_RANGE_CHECK_EN defined:
  - For ADDI, LW, SW and BEQ, an immediate outside [-2048, 2047] writes NOP 0x00000013 and sets err_o.
- Undefined:
  - The immediate is truncated to imm[11:0] without any flag.
  - err_o is set only by an illegal op.

## Structure
- The opcode/funct constants and the req_op enum belong in the shared opcodes header. The CPU decoder already uses that header for opcodes.
- One sub-module: instr_fifo, a synchronous FIFO with DEPTH entries and 32-bit words, plus flush and count outputs.
- The encoder mux, address register and error flag live in instr_encoder.

## Test plan
- After reset, ADDI rd=1 rs1=0 imm=5 -> mem_data_o=0x00500093, mem_addr_o=0x0 in cycle N+1; after ack, mem_addr_o=0x4.
- SW rs1=0 rs2=2 imm=8 -> 0x00202423.
- BEQ rs1=1 rs2=2 imm=-2 -> 0xFE208EE3, which the decoder round-trips to -2.
- Range check:
  - With IMM_RANGE_CHECK_EN, ADDI imm=3000 -> 0x00000013 and err_o=1.
  - err_clr_i pulse alone -> err_o=0.
  - Without the macro, the same request -> 0xBB800013 (imm[11:0]=0xBB8) and err_o=0.
- Back-pressure: mem_ack_i held low, push 4 requests -> count_o=4, req_ready_o=0. Then hold ack high -> writes at 0x0, 0x4, 0x8, 0xC in order.
- Flush and reset:
  - flush_i with 3 words buffered and valid_i high -> count_o=0, mem_addr_o=BASE_ADDR, no push.
  - rst_i low mid-stream -> all outputs return to their reset values.
